// File: rtl/mips_pipe_controller_if.sv
// Bundle of Decode inputs and stage control outputs between the IF/ID register,
// the hazard unit and the pipelined datapath.
interface mips_pipe_controller_if #(
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 32
);
  logic [5:0]           OpcodeD;
  logic [5:0]           FunctD;
  logic                 ValidD;
  logic                 FlushE;
  logic                 BranchD;
  logic                 BranchNeD;
  logic                 JumpD;
  logic                 IllegalD;
  logic                 RegWriteE;
  logic                 MemtoRegE;
  logic                 MemWriteE;
  logic                 ALUSrcE;
  logic                 RegDstE;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic                 RegWriteM;
  logic                 MemtoRegM;
  logic                 MemWriteM;
  logic                 RegWriteW;
  logic                 MemtoRegW;
  logic                 ValidW;
  logic                 IllegalW;
  logic [CNT_W-1:0]     RetireCount;

  modport master (
    output OpcodeD, FunctD, ValidD, FlushE,
    input  BranchD, BranchNeD, JumpD, IllegalD,
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
    input  RegWriteM, MemtoRegM, MemWriteM,
    input  RegWriteW, MemtoRegW, ValidW, IllegalW, RetireCount
  );

  modport slave (
    input  OpcodeD, FunctD, ValidD, FlushE,
    output BranchD, BranchNeD, JumpD, IllegalD,
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
    output RegWriteM, MemtoRegM, MemWriteM,
    output RegWriteW, MemtoRegW, ValidW, IllegalW, RetireCount
  );
endinterface

// File: rtl/mips_pipe_controller.sv
// Pipelined MIPS control: Decode-stage decoder plus E/M/W control registers and a
// retired-instruction counter. Define MIPS_PIPE_CTRL_EXT_OPS_EN to add bne/andi/ori/slti.
module mips_pipe_controller #(
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_pipe_controller_if.slave bus
);

  typedef struct packed {
    logic                 valid;
    logic                 illegal;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 mem_write;
    logic                 alu_src;
    logic                 reg_dst;
    logic [ALUCTRL_W-1:0] alu_ctrl;
  } e_ctrl_t;

  typedef struct packed {
    logic valid;
    logic illegal;
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } m_ctrl_t;

  typedef struct packed {
    logic valid;
    logic illegal;
    logic reg_write;
    logic mem_to_reg;
  } w_ctrl_t;

  e_ctrl_t          dec;
  e_ctrl_t          e_q;
  m_ctrl_t          m_q;
  w_ctrl_t          w_q;
  logic             branch;
  logic             branch_ne;
  logic             jump;
  logic             legal;
  logic [2:0]       alu3;
  logic [CNT_W-1:0] retire_q;

  always_comb begin
    dec       = '0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    jump      = 1'b0;
    legal     = 1'b1;
    alu3      = 3'b000;
    case (bus.OpcodeD)
      6'b000000: begin
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        case (bus.FunctD)
          6'b100000: alu3 = 3'b010;
          6'b100010: alu3 = 3'b110;
          6'b100100: alu3 = 3'b000;
          6'b100101: alu3 = 3'b001;
          6'b101010: alu3 = 3'b111;
          default:   legal = 1'b0;
        endcase
      end
      6'b100011: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        alu3           = 3'b010;
      end
      6'b101011: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        alu3          = 3'b010;
      end
      6'b000100: begin
        branch = 1'b1;
        alu3   = 3'b110;
      end
      6'b001000: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        alu3          = 3'b010;
      end
      6'b000010: jump = 1'b1;
`ifdef MIPS_PIPE_CTRL_EXT_OPS_EN
      6'b000101: begin
        branch_ne = 1'b1;
        alu3      = 3'b110;
      end
      6'b001100: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        alu3          = 3'b000;
      end
      6'b001101: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        alu3          = 3'b001;
      end
      6'b001010: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        alu3          = 3'b111;
      end
`endif
      default: legal = 1'b0;
    endcase
    dec.alu_ctrl = ALUCTRL_W'(alu3);
    // Illegal instructions still travel down the pipe, but with no side effects.
    if (!legal) begin
      dec       = '0;
      branch    = 1'b0;
      branch_ne = 1'b0;
      jump      = 1'b0;
    end
    dec.illegal = !legal;
    dec.valid   = 1'b1;
    if (!bus.ValidD) begin
      dec       = '0;
      branch    = 1'b0;
      branch_ne = 1'b0;
      jump      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      retire_q <= '0;
    end else begin
      e_q <= bus.FlushE ? '0 : dec;
      m_q <= '{valid: e_q.valid, illegal: e_q.illegal, reg_write: e_q.reg_write,
               mem_to_reg: e_q.mem_to_reg, mem_write: e_q.mem_write};
      w_q <= '{valid: m_q.valid, illegal: m_q.illegal, reg_write: m_q.reg_write,
               mem_to_reg: m_q.mem_to_reg};
      if (w_q.valid && !w_q.illegal) begin
        retire_q <= retire_q + CNT_W'(1);
      end
    end
  end

  assign bus.BranchD     = branch;
  assign bus.BranchNeD   = branch_ne;
  assign bus.JumpD       = jump;
  assign bus.IllegalD    = dec.illegal;
  assign bus.RegWriteE   = e_q.reg_write;
  assign bus.MemtoRegE   = e_q.mem_to_reg;
  assign bus.MemWriteE   = e_q.mem_write;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.RegDstE     = e_q.reg_dst;
  assign bus.ALUControlE = e_q.alu_ctrl;
  assign bus.RegWriteM   = m_q.reg_write;
  assign bus.MemtoRegM   = m_q.mem_to_reg;
  assign bus.MemWriteM   = m_q.mem_write;
  assign bus.RegWriteW   = w_q.reg_write;
  assign bus.MemtoRegW   = w_q.mem_to_reg;
  assign bus.ValidW      = w_q.valid;
  assign bus.IllegalW    = w_q.illegal;
  assign bus.RetireCount = retire_q;

endmodule

// File: tb/tb_mips_pipe_controller.sv
// Self-checking bench for mips_pipe_controller against an instruction-level model;
// honours MIPS_PIPE_CTRL_EXT_OPS_EN to match the build under test.
module tb_mips_pipe_controller;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       rw;
    logic       mtr;
    logic       mw;
    logic       as;
    logic       rd;
    logic [2:0] alu;
    logic       br;
    logic       bne;
    logic       j;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  exp_t        dcur, me, mm, mw;
  logic [31:0] mcnt;
  logic [2:0]  mcnt3;
  logic [3:0]  d_obs, d_exp;
  logic [49:0] r_obs, r_exp;

  mips_pipe_controller_if #(.ALUCTRL_W(3), .CNT_W(32)) bus ();
  mips_pipe_controller_if #(.ALUCTRL_W(3), .CNT_W(3))  bus3 ();

  mips_pipe_controller #(.ALUCTRL_W(3), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  mips_pipe_controller #(.ALUCTRL_W(3), .CNT_W(3)) dut_w (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  assign bus3.OpcodeD = bus.OpcodeD;
  assign bus3.FunctD  = bus.FunctD;
  assign bus3.ValidD  = bus.ValidD;
  assign bus3.FlushE  = bus.FlushE;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction-level expectation straight from the opcode/funct table.
  function automatic exp_t ref_decode(input logic [5:0] op, input logic [5:0] fn, input logic vd);
    exp_t b;
    bit   ok;
    b  = '0;
    ok = 1'b1;
    case (op)
      6'b000000: begin
        b.rw = 1; b.rd = 1;
        case (fn)
          6'b100000: b.alu = 3'b010;
          6'b100010: b.alu = 3'b110;
          6'b100100: b.alu = 3'b000;
          6'b100101: b.alu = 3'b001;
          6'b101010: b.alu = 3'b111;
          default:   ok = 1'b0;
        endcase
      end
      6'b100011: begin b.rw = 1; b.as = 1; b.mtr = 1; b.alu = 3'b010; end
      6'b101011: begin b.mw = 1; b.as = 1; b.alu = 3'b010; end
      6'b000100: begin b.br = 1; b.alu = 3'b110; end
      6'b001000: begin b.rw = 1; b.as = 1; b.alu = 3'b010; end
      6'b000010: b.j = 1;
`ifdef MIPS_PIPE_CTRL_EXT_OPS_EN
      6'b000101: begin b.bne = 1; b.alu = 3'b110; end
      6'b001100: begin b.rw = 1; b.as = 1; b.alu = 3'b000; end
      6'b001101: begin b.rw = 1; b.as = 1; b.alu = 3'b001; end
      6'b001010: begin b.rw = 1; b.as = 1; b.alu = 3'b111; end
`endif
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      b = '0;
      b.illegal = 1'b1;
    end
    b.valid = 1'b1;
    if (!vd) b = '0;
    return b;
  endfunction

  // Drives one cycle, samples D before the edge, advances the model, samples E/M/W after.
  task automatic tick(input logic [5:0] op, input logic [5:0] fn, input logic vd,
                      input logic fl, input logic rs);
    bus.OpcodeD = op;
    bus.FunctD  = fn;
    bus.ValidD  = vd;
    bus.FlushE  = fl;
    reset       = rs;
    #2;
    dcur  = ref_decode(op, fn, vd);
    d_obs = {bus.BranchD, bus.BranchNeD, bus.JumpD, bus.IllegalD};
    d_exp = {dcur.br, dcur.bne, dcur.j, dcur.illegal};
    @(posedge clk);
    if (rs) begin
      me = '0; mm = '0; mw = '0; mcnt = '0; mcnt3 = '0;
    end else begin
      if (mw.valid && !mw.illegal) begin
        mcnt  = mcnt + 1;
        mcnt3 = mcnt3 + 1;
      end
      mw = mm;
      mm = me;
      me = fl ? '0 : dcur;
    end
    #1;
    r_obs = {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ALUSrcE, bus.RegDstE,
             bus.ALUControlE, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM,
             bus.RegWriteW, bus.MemtoRegW, bus.ValidW, bus.IllegalW,
             bus.RetireCount, bus3.RetireCount};
    r_exp = {me.rw, me.mtr, me.mw, me.as, me.rd, me.alu, mm.rw, mm.mtr, mm.mw,
             mw.rw, mw.mtr, mw.valid, mw.illegal, mcnt, mcnt3};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(6'b100011, 6'b000000, 1'b1, 1'b0, 1'b1);
      checks++;
      if (r_obs !== 50'd0) begin
        failures++;
        $display("[TB] FAIL reset_regs cycle %0d: got %h expected 0", i, r_obs);
      end
      checks++;
      if (d_obs !== d_exp) begin
        failures++;
        $display("[TB] FAIL reset_dstage cycle %0d: got %b expected %b", i, d_obs, d_exp);
      end
    end
  endtask

  task automatic test_sequence();
    logic [5:0] ops [6];
    logic [5:0] rw_hist;
    logic [1:0] e_hits;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    rw_hist = '0;
    e_hits  = '0;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) tick(ops[i], (i == 0) ? 6'b100000 : 6'($urandom), 1'b1, 1'b0, 1'b0);
      else       tick(6'($urandom), 6'($urandom), 1'b0, 1'b0, 1'b0);
      if (i == 0) e_hits[0] = (bus.ALUControlE === 3'b010) && (bus.RegDstE === 1'b1);
      if (i == 1) e_hits[1] = (bus.MemtoRegE === 1'b1) && (bus.ALUSrcE === 1'b1);
      if (i >= 2 && i <= 7) rw_hist[7-i] = bus.RegWriteW;
      checks++;
      if (d_obs !== d_exp) begin
        failures++;
        $display("[TB] FAIL seq_dstage step %0d: got %b expected %b", i, d_obs, d_exp);
      end
      checks++;
      if (r_obs !== r_exp) begin
        failures++;
        $display("[TB] FAIL seq_regs step %0d: got %h expected %h", i, r_obs, r_exp);
      end
    end
    checks++;
    if (e_hits !== 2'b11) begin
      failures++;
      $display("[TB] FAIL seq_estage: got %b expected 11", e_hits);
    end
    checks++;
    if (rw_hist !== 6'b110010) begin
      failures++;
      $display("[TB] FAIL seq_regwritew: got %b expected 110010", rw_hist);
    end
    checks++;
    if (bus.RetireCount !== 32'd6) begin
      failures++;
      $display("[TB] FAIL seq_retire: got %0d expected 6", bus.RetireCount);
    end
  endtask

  task automatic test_flush();
    logic [5:0]  ops [4];
    logic [31:0] start;
    logic        sw_seen;
    ops     = '{6'b000000, 6'b100011, 6'b101011, 6'b001000};
    start   = mcnt;
    sw_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) tick(ops[i], 6'b100010, 1'b1, (i == 2), 1'b0);
      else       tick(6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0);
      if (i == 2 || i == 3) sw_seen = sw_seen | bus.MemWriteE | bus.MemWriteM;
      if (i == 4) begin
        checks++;
        if (bus.ValidW !== 1'b0) begin
          failures++;
          $display("[TB] FAIL flush_validw: got %b expected 0", bus.ValidW);
        end
      end
      checks++;
      if (r_obs !== r_exp) begin
        failures++;
        $display("[TB] FAIL flush_regs step %0d: got %h expected %h", i, r_obs, r_exp);
      end
    end
    checks++;
    if (sw_seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_memwrite: got %b expected 0", sw_seen);
    end
    checks++;
    if (bus.RetireCount !== start + 32'd3) begin
      failures++;
      $display("[TB] FAIL flush_retire: got %0d expected %0d", bus.RetireCount, start + 32'd3);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] start;
    start = mcnt;
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      tick(6'b111111, 6'b100000, 1'b1, 1'b0, 1'b0);
      else if (i == 1) tick(6'b000000, 6'b000000, 1'b1, 1'b0, 1'b0);
      else             tick(6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0);
      if (i < 2) begin
        checks++;
        if (d_obs !== 4'b0001) begin
          failures++;
          $display("[TB] FAIL illegal_dstage step %0d: got %b expected 0001", i, d_obs);
        end
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (bus.IllegalW !== 1'b1 || bus.ValidW !== 1'b1 || bus.RegWriteW !== 1'b0) begin
          failures++;
          $display("[TB] FAIL illegal_wstage step %0d: got ill=%b val=%b rw=%b expected 1 1 0",
                   i, bus.IllegalW, bus.ValidW, bus.RegWriteW);
        end
      end
      checks++;
      if (r_obs !== r_exp) begin
        failures++;
        $display("[TB] FAIL illegal_regs step %0d: got %h expected %h", i, r_obs, r_exp);
      end
    end
    checks++;
    if (bus.RetireCount !== start) begin
      failures++;
      $display("[TB] FAIL illegal_retire: got %0d expected %0d", bus.RetireCount, start);
    end
  endtask

  task automatic test_ext_ops();
    logic [5:0] ops [4];
    logic       ext_on;
`ifdef MIPS_PIPE_CTRL_EXT_OPS_EN
    ext_on = 1'b1;
`else
    ext_on = 1'b0;
`endif
    ops = '{6'b001101, 6'b000101, 6'b001100, 6'b001010};
    for (int i = 0; i < 7; i++) begin
      if (i < 4) tick(ops[i], 6'($urandom), 1'b1, 1'b0, 1'b0);
      else       tick(6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0);
      if (i == 0) begin
        checks++;
        if (bus.RegWriteE !== ext_on || bus.ALUControlE !== (ext_on ? 3'b001 : 3'b000)
            || d_obs[0] !== !ext_on) begin
          failures++;
          $display("[TB] FAIL ext_ori: got rw=%b alu=%b ill=%b with ext=%b",
                   bus.RegWriteE, bus.ALUControlE, d_obs[0], ext_on);
        end
      end
      if (i == 1) begin
        checks++;
        if (d_obs[2] !== ext_on) begin
          failures++;
          $display("[TB] FAIL ext_bne: got %b expected %b", d_obs[2], ext_on);
        end
      end
      checks++;
      if (d_obs !== d_exp) begin
        failures++;
        $display("[TB] FAIL ext_dstage step %0d: got %b expected %b", i, d_obs, d_exp);
      end
      checks++;
      if (r_obs !== r_exp) begin
        failures++;
        $display("[TB] FAIL ext_regs step %0d: got %h expected %h", i, r_obs, r_exp);
      end
    end
  endtask

  task automatic test_reset_priority();
    tick(6'b001000, 6'b000000, 1'b1, 1'b0, 1'b0);
    tick(6'b001000, 6'b000000, 1'b0, 1'b0, 1'b0);
    tick(6'b100011, 6'b000000, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.ValidW !== 1'b0 || bus.RetireCount !== 32'd0) begin
        failures++;
        $display("[TB] FAIL rstprio step %0d: got validw=%b cnt=%0d expected 0 0",
                 i, bus.ValidW, bus.RetireCount);
      end
      checks++;
      if (r_obs !== r_exp) begin
        failures++;
        $display("[TB] FAIL rstprio_regs step %0d: got %h expected %h", i, r_obs, r_exp);
      end
    end
  endtask

  task automatic test_wrap();
    tick(6'b000000, 6'b000000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) begin
      tick(6'b001000, 6'($urandom), (i < 9), 1'b0, 1'b0);
      checks++;
      if (r_obs !== r_exp) begin
        failures++;
        $display("[TB] FAIL wrap_regs step %0d: got %h expected %h", i, r_obs, r_exp);
      end
    end
    checks++;
    if (bus3.RetireCount !== 3'd1 || bus.RetireCount !== 32'd9) begin
      failures++;
      $display("[TB] FAIL wrap_count: got %0d/%0d expected 1/9", bus3.RetireCount, bus.RetireCount);
    end
  endtask

  task automatic test_random();
    logic [5:0] op_pool [12];
    logic [5:0] fn_pool [6];
    logic [5:0] op, fn;
    op_pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010,
                6'b000101, 6'b001100, 6'b001101, 6'b001010, 6'b000000, 6'b111111};
    fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    for (int i = 0; i < 400; i++) begin
      op = ($urandom % 5 == 0) ? 6'($urandom) : op_pool[$urandom % 12];
      fn = ($urandom % 5 == 0) ? 6'($urandom) : fn_pool[$urandom % 6];
      tick(op, fn, ($urandom % 4 != 0), ($urandom % 6 == 0), ($urandom % 60 == 0));
      checks++;
      if (d_obs !== d_exp) begin
        failures++;
        $display("[TB] FAIL rand_dstage step %0d op=%b fn=%b: got %b expected %b",
                 i, op, fn, d_obs, d_exp);
      end
      checks++;
      if (r_obs !== r_exp) begin
        failures++;
        $display("[TB] FAIL rand_regs step %0d: got %h expected %h", i, r_obs, r_exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    me = '0; mm = '0; mw = '0; mcnt = '0; mcnt3 = '0;
    reset       = 1'b1;
    bus.OpcodeD = 6'b0;
    bus.FunctD  = 6'b0;
    bus.ValidD  = 1'b0;
    bus.FlushE  = 1'b0;
    test_reset();
    test_sequence();
    test_flush();
    test_illegal();
    test_ext_ops();
    test_reset_priority();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
